// File: rtl/key_report_pkg.sv
// rtl/key_report_pkg.sv - shared constants, FSM encoding and sizing helper for key_report_tx
// Contents: HEADER_DEFAULT, MODE_SNAPSHOT/MODE_EVENT, state_t, nbytes()
package key_report_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         MODE_SNAPSHOT  = 0;
  localparam int         MODE_EVENT     = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // Number of bytes needed to carry n key bits.
  function automatic int nbytes(input int n);
    return (n + 7) / 8;
  endfunction

endpackage

// File: rtl/key_report_tx_if.sv
// rtl/key_report_tx_if.sv - uart byte handshake between key_report_tx and the uart transmitter
// Signals: uart_send (start pulse), send_data (byte), uart_send_done (byte finished pulse)
// Modports: master = reporter side, slave = uart side
interface key_report_tx_if;

  logic       uart_send;
  logic [7:0] send_data;
  logic       uart_send_done;

  modport master (
    output uart_send,
    output send_data,
    input  uart_send_done
  );

  modport slave (
    input  uart_send,
    input  send_data,
    output uart_send_done
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - single-key debouncer: candidate bit plus saturating match counter
// Ports: clk, rst (sync, active high), i_valid (sample strobe), i_sample (raw key), o_stable (debounced key)
module key_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_sample,
  output logic o_stable
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic       r_cand;
  logic [3:0] r_cnt;
  logic       r_stable;
  logic       w_cand_next;
  logic [3:0] w_cnt_next;

  always_comb begin
    w_cand_next = r_cand;
    w_cnt_next  = r_cnt;
    if (i_sample == r_cand) begin
      if (r_cnt != DEB) begin
        w_cnt_next = r_cnt + 4'd1;
      end
    end else begin
      w_cand_next = i_sample;
      w_cnt_next  = 4'd1;
    end
  end

  // The stable bit follows the candidate on the same strobe the count hits DEBOUNCE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand   <= 1'b0;
      r_cnt    <= 4'd0;
      r_stable <= 1'b0;
    end else if (i_valid) begin
      r_cand <= w_cand_next;
      r_cnt  <= w_cnt_next;
      if (w_cnt_next == DEB) begin
        r_stable <= w_cand_next;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/key_report_tx.sv
// rtl/key_report_tx.sv - debounces a key vector and reports changes over the uart byte handshake
// Ports: clk, rst (sync, active high), i_key_down/i_key_valid (raw keys + strobe),
//        i_force_snapshot (frame request), uart (master handshake), o_keys_stable (debounced keys),
//        o_busy (FSM not idle), o_drop_cnt (saturating count of force requests lost while busy)
module key_report_tx
  import key_report_pkg::*;
#(
  parameter int         NUM_KEYS = 40,
  parameter int         DEBOUNCE = 3,
  parameter int         MODE     = MODE_SNAPSHOT,
  parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] i_key_down,
  input  logic                i_key_valid,
  input  logic                i_force_snapshot,
  key_report_tx_if.master     uart,
  output logic [NUM_KEYS-1:0] o_keys_stable,
  output logic                o_busy,
  output logic [7:0]          o_drop_cnt
);

  localparam int             NB       = nbytes(NUM_KEYS);
  localparam int             IDX_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:0] r_reported;
  logic [NUM_KEYS-1:0] w_pending;
  logic [NUM_KEYS-1:0] w_low_oh;
  logic [6:0]          w_low_k;
  logic                w_low_val;
  logic [NB*8-1:0]     r_snap;
  logic [NB*8-1:0]     w_stable_pad;
  logic [IDX_W-1:0]    r_idx;
  logic [7:0]          r_data;
  logic [7:0]          r_drop;
  logic [7:0]          w_csum;
  logic [7:0]          w_next_byte;
  logic                r_force;
  logic                w_frame_done;
  logic                w_force_ok;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_key_valid),
      .i_sample (i_key_down[k]),
      .o_stable (w_stable[k])
    );
  end

  assign w_pending  = w_stable ^ r_reported;
  assign w_force_ok = (MODE == MODE_SNAPSHOT) && i_force_snapshot;

  // Lowest pending key: isolate the lowest set bit, then encode its index.
  assign w_low_oh  = w_pending & (~w_pending + 1'b1);
  assign w_low_val = |(w_stable & w_low_oh);

  always_comb begin
    w_low_k = 7'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_low_oh[i]) begin
        w_low_k = 7'(i);
      end
    end
  end

  always_comb begin
    w_stable_pad                 = '0;
    w_stable_pad[NUM_KEYS-1:0]   = w_stable;
  end

  always_comb begin
    w_csum = 8'd0;
    for (int i = 0; i < NB; i++) begin
      w_csum = w_csum ^ r_snap[8*i +: 8];
    end
  end

  // Byte for index r_idx+1: data byte r_idx while data remains, else the checksum.
  always_comb begin
    w_next_byte = w_csum;
    for (int i = 0; i < NB; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_next_byte = r_snap[8*i +: 8];
      end
    end
  end

  assign w_frame_done = (MODE == MODE_EVENT) || (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if ((w_pending != '0) || ((MODE == MODE_SNAPSHOT) && r_force)) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: w_state_next = ST_SEND;
      ST_SEND: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (uart.uart_send_done) begin
          w_state_next = w_frame_done ? ST_IDLE : ST_SEND;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reported <= '0;
      r_snap     <= '0;
      r_idx      <= '0;
      r_data     <= 8'd0;
      r_drop     <= 8'd0;
      r_force    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_force_ok) begin
            r_force <= 1'b1;
          end
        end
        ST_LOAD: begin
          // A force arriving during LOAD is served by the frame being loaded.
          r_force <= 1'b0;
          r_idx   <= '0;
          if (MODE == MODE_SNAPSHOT) begin
            r_snap     <= w_stable_pad;
            r_reported <= w_stable;
            r_data     <= HEADER;
          end else begin
            r_reported <= r_reported ^ w_low_oh;
            r_data     <= {w_low_val, w_low_k};
          end
        end
        default: begin
          if (w_force_ok && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
          end
          if ((r_state == ST_WAIT) && uart.uart_send_done && !w_frame_done) begin
            r_idx  <= r_idx + 1'b1;
            r_data <= w_next_byte;
          end
        end
      endcase
    end
  end

  assign uart.uart_send = (r_state == ST_SEND);
  assign uart.send_data = r_data;
  assign o_keys_stable  = w_stable;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_drop_cnt     = r_drop;

endmodule

// File: tb/tb_key_report_tx.sv
// tb/tb_key_report_tx.sv - randomized self-checking bench for key_report_tx in snapshot and event modes
module tb_key_report_tx;
  import key_report_pkg::*;

  localparam int NK  = 40;
  localparam int DEB = 3;
  localparam int NB  = (NK + 7) / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a  [2];
  logic [NK-1:0] kd     [2];
  logic          kv     [2];
  logic          fs     [2];
  logic [NK-1:0] ks_o   [2];
  logic          busy_o [2];
  logic [7:0]    drop_o [2];
  logic          hold   [2];
  logic          xdone  [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  // Reference model: a key's debounced value is set whenever its last DEB samples agree.
  logic [NK-1:0] st_m [2];
  logic [NK-1:0] hist [2][DEB];
  int            hcnt [2];

  key_report_tx_if u_if0 ();
  key_report_tx_if u_if1 ();

  key_report_tx #(.NUM_KEYS(NK), .DEBOUNCE(DEB), .MODE(MODE_SNAPSHOT), .HEADER(8'hA5)) u_dut_snap (
    .clk              (clk),
    .rst              (rst_a[0]),
    .i_key_down       (kd[0]),
    .i_key_valid      (kv[0]),
    .i_force_snapshot (fs[0]),
    .uart             (u_if0),
    .o_keys_stable    (ks_o[0]),
    .o_busy           (busy_o[0]),
    .o_drop_cnt       (drop_o[0])
  );

  key_report_tx #(.NUM_KEYS(NK), .DEBOUNCE(DEB), .MODE(MODE_EVENT), .HEADER(8'hA5)) u_dut_evt (
    .clk              (clk),
    .rst              (rst_a[1]),
    .i_key_down       (kd[1]),
    .i_key_valid      (kv[1]),
    .i_force_snapshot (fs[1]),
    .uart             (u_if1),
    .o_keys_stable    (ks_o[1]),
    .o_busy           (busy_o[1]),
    .o_drop_cnt       (drop_o[1])
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // uart stand-in: records each byte, checks it is held, answers after 1..3 cycles unless held off.
  for (genvar g = 0; g < 2; g++) begin : g_resp
    logic       snd;
    logic [7:0] dat;
    logic       done_r  = 1'b0;
    logic       waiting = 1'b0;
    logic [7:0] cur     = 8'h00;
    int         cd      = 0;

    if (g == 0) begin : g_c0
      assign snd                  = u_if0.uart_send;
      assign dat                  = u_if0.send_data;
      assign u_if0.uart_send_done = done_r | xdone[0];
    end else begin : g_c1
      assign snd                  = u_if1.uart_send;
      assign dat                  = u_if1.send_data;
      assign u_if1.uart_send_done = done_r | xdone[1];
    end

    always @(negedge clk) begin
      done_r = 1'b0;
      if (rst_a[g]) begin
        waiting = 1'b0;
      end else if (waiting) begin
        check($sformatf("hold_data%0d", g), dat, cur);
        check($sformatf("no_resend%0d", g), snd, 1'b0);
        if (!hold[g]) begin
          cd--;
          if (cd <= 0) begin
            done_r  = 1'b1;
            waiting = 1'b0;
          end
        end
      end else if (snd === 1'b1) begin
        got_q.push_back(dat);
        cur     = dat;
        cd      = $urandom_range(1, 3);
        waiting = 1'b1;
      end
    end
  end

  task automatic push_frame(input logic [NK-1:0] m);
    logic [NB*8-1:0] pad;
    logic [7:0]      cs;
    logic [7:0]      by;
    pad         = '0;
    pad[NK-1:0] = m;
    cs          = 8'h00;
    exp_q.push_back(8'hA5);
    for (int b = 0; b < NB; b++) begin
      by = pad[8*b +: 8];
      cs = cs ^ by;
      exp_q.push_back(by);
    end
    exp_q.push_back(cs);
  endtask

  task automatic model_reset(input int g);
    st_m[g] = '0;
    hcnt[g] = 0;
    for (int i = 0; i < DEB; i++) hist[g][i] = '0;
  endtask

  task automatic model_sample(input int g, input logic [NK-1:0] v);
    logic [NK-1:0] nw;
    logic [NK-1:0] chg;
    bit            same;
    for (int i = DEB - 1; i > 0; i--) hist[g][i] = hist[g][i-1];
    hist[g][0] = v;
    if (hcnt[g] < DEB) hcnt[g]++;
    nw = st_m[g];
    if (hcnt[g] >= DEB) begin
      for (int k = 0; k < NK; k++) begin
        same = 1'b1;
        for (int i = 1; i < DEB; i++) if (hist[g][i][k] != v[k]) same = 1'b0;
        if (same) nw[k] = v[k];
      end
    end
    chg = nw ^ st_m[g];
    if (chg != '0) begin
      if (g == 0) begin
        push_frame(nw);
      end else begin
        for (int k = 0; k < NK; k++) if (chg[k]) exp_q.push_back({nw[k], 7'(k)});
      end
    end
    st_m[g] = nw;
  endtask

  task automatic strobe(input int g, input logic [NK-1:0] v);
    @(negedge clk);
    kd[g] = v;
    kv[g] = 1'b1;
    @(negedge clk);
    kv[g] = 1'b0;
    model_sample(g, v);
    check($sformatf("keys_stable%0d", g), ks_o[g], st_m[g]);
  endtask

  task automatic settle(input int g);
    int quiet = 0;
    int n     = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      quiet = busy_o[g] ? 0 : quiet + 1;
    end
    check($sformatf("settle%0d", g), (n < 3000), 1'b1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_force(input int g);
    @(negedge clk);
    fs[g] = 1'b1;
    @(negedge clk);
    fs[g] = 1'b0;
  endtask

  task automatic random_run(input int g, input int groups);
    logic [NK-1:0] v;
    logic [NK-1:0] m;
    v = kd[g];
    for (int i = 0; i < groups; i++) begin
      m = '0;
      repeat ($urandom_range(0, 3)) m[$urandom_range(0, NK - 1)] = 1'b1;
      v = v ^ m;
      repeat ($urandom_range(1, 4)) begin
        strobe(g, v);
        settle(g);
      end
    end
    compare($sformatf("random%0d", g));
  endtask

  initial begin
    int n;
    int bad;
    for (int g = 0; g < 2; g++) begin
      rst_a[g] = 1'b1;
      kd[g]    = '0;
      kv[g]    = 1'b0;
      fs[g]    = 1'b0;
      hold[g]  = 1'b0;
      xdone[g] = 1'b0;
      model_reset(g);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_busy%0d", g), busy_o[g], 1'b0);
      check($sformatf("rst_ks%0d", g), ks_o[g], '0);
      check($sformatf("rst_drop%0d", g), drop_o[g], 8'd0);
    end
    check("rst_send0", u_if0.uart_send, 1'b0);
    check("rst_data0", u_if0.send_data, 8'd0);
    check("rst_send1", u_if1.uart_send, 1'b0);
    check("rst_data1", u_if1.send_data, 8'd0);
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;

    // Snapshot: two strobes are not enough, the third produces a frame.
    repeat (2) begin
      strobe(0, 40'h00_0000_0001);
      settle(0);
    end
    compare("pre_debounce");
    strobe(0, 40'h00_0000_0001);
    settle(0);
    check("first_frame_len", got_q.size(), 7);
    compare("first_frame");

    // Glitch on key 5.
    strobe(0, 40'h21); settle(0);
    strobe(0, 40'h21); settle(0);
    strobe(0, 40'h01); settle(0);
    strobe(0, 40'h21); settle(0);
    strobe(0, 40'h21); settle(0);
    strobe(0, 40'h21); settle(0);
    compare("glitch");

    // Force with nothing changed, then back to an all-zero map for the force/drop checks.
    repeat (3) begin
      strobe(0, '0);
      settle(0);
    end
    compare("release_all");
    pulse_force(0);
    push_frame(st_m[0]);
    settle(0);
    compare("force_idle");

    // Force during WAIT is dropped; done withheld for 1000 cycles.
    hold[0] = 1'b1;
    pulse_force(0);
    push_frame(st_m[0]);
    n = 0;
    while (got_q.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_start", got_q.size(), 1);
    pulse_force(0);
    check("drop_cnt", drop_o[0], 8'd1);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!busy_o[0]) bad++;
    end
    check("hold_busy_low", bad, 0);
    check("hold_no_more", got_q.size(), 1);
    hold[0] = 1'b0;
    settle(0);
    compare("force_drop");

    // Stray done while idle.
    @(posedge clk); #2 xdone[0] = 1'b1;
    @(posedge clk); #2 xdone[0] = 1'b0;
    settle(0);
    check("idle_done_busy", busy_o[0], 1'b0);
    check("idle_done_drop", drop_o[0], 8'd1);
    compare("idle_done");

    random_run(0, 25);

    // Reset in the middle of a frame.
    strobe(0, st_m[0] ^ 40'h12_3456_789A); settle(0);
    strobe(0, kd[0]);                      settle(0);
    compare("pre_abort");
    strobe(0, kd[0]);
    n = 0;
    while (got_q.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_third_byte", (got_q.size() >= 3), 1'b1);
    rst_a[0] = 1'b1;
    @(negedge clk);
    check("abort_send", u_if0.uart_send, 1'b0);
    check("abort_busy", busy_o[0], 1'b0);
    check("abort_ks", ks_o[0], '0);
    check("abort_drop", drop_o[0], 8'd0);
    @(negedge clk);
    rst_a[0] = 1'b0;
    model_reset(0);
    got_q.delete();
    exp_q.delete();
    repeat (3) begin
      strobe(0, 40'hC3_0000_5A81);
      settle(0);
    end
    compare("after_abort");

    // Event mode.
    repeat (3) begin
      strobe(1, (40'd1 << 3) | (40'd1 << 39));
      settle(1);
    end
    check("ev_press_first", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'h83);
    compare("ev_press");
    repeat (3) begin
      strobe(1, 40'd1 << 39);
      settle(1);
    end
    check("ev_release_first", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'h03);
    compare("ev_release");
    pulse_force(1);
    settle(1);
    check("ev_force_drop", drop_o[1], 8'd0);
    compare("ev_force");
    random_run(1, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
